// File: rtl/exe_issue_ctrl_pkg.sv
// Shared types for the EXE issue/hazard controller.
// Slot bookkeeping, FSM states and operand mux select encoding.
package exe_issue_ctrl_pkg;

  localparam int SLOT_AW = 5;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               wr_rd;
    logic               is_load;
  } exe_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MC   = 2'd2,
    ST_HOLD = 2'd3
  } exe_ctrl_state_t;

  typedef enum logic [1:0] {
    REGFILE = 2'b00,
    EXE_FWD = 2'b01,
    MEM_FWD = 2'b10
  } rs_sel_t;

  // x0 and non-writing slots never produce a hazard
  function automatic logic slot_match(
    input exe_slot_t          s,
    input logic [SLOT_AW-1:0] addr
  );
    return s.valid & s.wr_rd & (s.rd != '0) & (s.rd == addr);
  endfunction

endpackage

// File: rtl/exe_fwd_sel.sv
// Forwarding source select for one operand.
// Youngest producer (EXE) wins over MEM.
module exe_fwd_sel
  import exe_issue_ctrl_pkg::*;
(
  input  logic [SLOT_AW-1:0] addr,
  input  logic               use_src,
  input  exe_slot_t          ex_slot,
  input  exe_slot_t          mem_slot,
  output rs_sel_t            sel
);

  logic hit_ex;
  logic hit_mem;

  assign hit_ex  = use_src & slot_match(ex_slot, addr);
  assign hit_mem = use_src & slot_match(mem_slot, addr) & !hit_ex;

  always_comb begin
    sel = REGFILE;
    unique case (1'b1)
      hit_ex:  sel = EXE_FWD;
      hit_mem: sel = MEM_FWD;
      default: sel = REGFILE;
    endcase
  end

endmodule

// File: rtl/exe_issue_ctrl.sv
// Issue/hazard controller between decode and EXE: slot scoreboard,
// registered forwarding selects, load-use stall, multicycle and flush.
module exe_issue_ctrl
  import exe_issue_ctrl_pkg::*;
#(
  parameter int MC_CYCLES = 4,
  parameter int REG_AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_wr_rd_i,
  input  logic              id_is_load_i,
  input  logic              id_is_mc_i,
  input  logic              flush_i,
  input  logic              mem_ready_i,
  output logic              exe_en_o,
  output logic              exe_valid_o,
  output logic [1:0]        rs1_sel_o,
  output logic [1:0]        rs2_sel_o,
  output logic              mc_start_o
);

  localparam int CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [CW-1:0] MC_LOAD = CW'(MC_CYCLES - 1);

  if (REG_AW != SLOT_AW) begin : g_aw_chk
    $error("REG_AW must equal SLOT_AW");
  end

  exe_ctrl_state_t state;
  exe_slot_t       ex_q;
  exe_slot_t       mem_q;
  exe_slot_t       new_slot;
  logic [CW-1:0]   mc_cnt;
  rs_sel_t         rs1_q;
  rs_sel_t         rs2_q;
  rs_sel_t         rs1_d;
  rs_sel_t         rs2_d;
  logic            mc_start_q;

  logic done;
  logic exe_valid;
  logic adv;
  logic load_use;
  logic flush_eff;
  logic ready;
  logic accept;

  exe_fwd_sel u_rs1_sel (
    .addr     (id_rs1_i),
    .use_src  (id_use_rs1_i),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (rs1_d)
  );

  exe_fwd_sel u_rs2_sel (
    .addr     (id_rs2_i),
    .use_src  (id_use_rs2_i),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .sel      (rs2_d)
  );

  assign done      = (state != ST_MC) | (mc_cnt == '0);
  assign exe_valid = ex_q.valid & done;
  assign adv       = done & (!ex_q.valid | mem_ready_i);
  assign flush_eff = flush_i & exe_valid;

  assign load_use = ex_q.is_load &
    ((id_use_rs1_i & slot_match(ex_q, id_rs1_i)) |
     (id_use_rs2_i & slot_match(ex_q, id_rs2_i)));

  // handshake outputs are forced low while reset is asserted
  assign ready  = rst & adv & (!load_use | flush_eff);
  assign accept = ready & id_valid_i & !flush_eff;

  assign new_slot = '{valid:   1'b1,
                      rd:      id_rd_i,
                      wr_rd:   id_wr_rd_i,
                      is_load: id_is_load_i};

  assign id_ready_o  = ready;
  assign exe_en_o    = rst & adv;
  assign exe_valid_o = exe_valid;
  assign rs1_sel_o   = rs1_q;
  assign rs2_sel_o   = rs2_q;
  assign mc_start_o  = mc_start_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ex_q       <= '0;
      mem_q      <= '0;
      mc_cnt     <= '0;
      rs1_q      <= REGFILE;
      rs2_q      <= REGFILE;
      mc_start_q <= 1'b0;
    end else begin
      mc_start_q <= 1'b0;
      if (adv) begin
        mem_q <= exe_valid ? ex_q : '0;
        if (accept) begin
          ex_q  <= new_slot;
          rs1_q <= rs1_d;
          rs2_q <= rs2_d;
          mc_cnt <= '0;
          state  <= ST_RUN;
          if (id_is_mc_i) begin
            mc_start_q <= 1'b1;
            if (MC_CYCLES > 1) begin
              state  <= ST_MC;
              mc_cnt <= MC_LOAD;
            end
          end
        end else begin
          ex_q  <= '0;
          rs1_q <= REGFILE;
          rs2_q <= REGFILE;
          state <= ST_IDLE;
        end
      end else if (state == ST_MC && mc_cnt != '0) begin
        mc_cnt <= mc_cnt - CW'(1);
      end else if (state != ST_HOLD) begin
        state <= ST_HOLD;
      end
    end
  end

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Directed bench for exe_issue_ctrl: forwarding, load-use,
// multicycle, hold, flush and async reset.
module tb_exe_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid_i;
  logic       id_ready_o;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_use_rs1_i;
  logic       id_use_rs2_i;
  logic [4:0] id_rd_i;
  logic       id_wr_rd_i;
  logic       id_is_load_i;
  logic       id_is_mc_i;
  logic       flush_i;
  logic       mem_ready_i;
  logic       exe_en_o;
  logic       exe_valid_o;
  logic [1:0] rs1_sel_o;
  logic [1:0] rs2_sel_o;
  logic       mc_start_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exe_issue_ctrl #(.MC_CYCLES(4), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid_i   (id_valid_i),
    .id_ready_o   (id_ready_o),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .id_rd_i      (id_rd_i),
    .id_wr_rd_i   (id_wr_rd_i),
    .id_is_load_i (id_is_load_i),
    .id_is_mc_i   (id_is_mc_i),
    .flush_i      (flush_i),
    .mem_ready_i  (mem_ready_i),
    .exe_en_o     (exe_en_o),
    .exe_valid_o  (exe_valid_o),
    .rs1_sel_o    (rs1_sel_o),
    .rs2_sel_o    (rs2_sel_o),
    .mc_start_o   (mc_start_o)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld,
                       input logic mc);
    id_valid_i   = v;
    id_rs1_i     = rs1;
    id_use_rs1_i = u1;
    id_rs2_i     = rs2;
    id_use_rs2_i = u2;
    id_rd_i      = rd;
    id_wr_rd_i   = wr;
    id_is_load_i = ld;
    id_is_mc_i   = mc;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_sels(input string tag, input logic [1:0] s1,
                          input logic [1:0] s2);
    check({tag, "_rs1"}, 32'(rs1_sel_o), 32'(s1));
    check({tag, "_rs2"}, 32'(rs2_sel_o), 32'(s2));
  endtask

  initial begin
    rst         = 1'b0;
    flush_i     = 1'b0;
    mem_ready_i = 1'b1;
    idle();
    #12;
    check("rst_ready", 32'(id_ready_o), 0);
    check("rst_en", 32'(exe_en_o), 0);
    check("rst_valid", 32'(exe_valid_o), 0);
    check("rst_mcs", 32'(mc_start_o), 0);
    chk_sels("rst", 2'b00, 2'b00);
    step();
    rst = 1'b1;

    // addi x1, x0, imm
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    check("addi_ready", 32'(id_ready_o), 1);
    step();
    check("addi_valid", 32'(exe_valid_o), 1);
    chk_sels("addi", 2'b00, 2'b00);
    // add x2, x1, x1
    drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    check("add2_ready", 32'(id_ready_o), 1);
    step();
    chk_sels("add2", 2'b01, 2'b01);
    // add x5, x1, x0
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    chk_sels("add5", 2'b10, 2'b00);

    // lw x3, 0(x0) then add x4, x3, x0
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    check("lu_ready", 32'(id_ready_o), 0);
    check("lu_en", 32'(exe_en_o), 1);
    step();
    check("lu_bub_valid", 32'(exe_valid_o), 0);
    chk_sels("lu_bub", 2'b00, 2'b00);
    check("lu_ready2", 32'(id_ready_o), 1);
    step();
    chk_sels("lu_dep", 2'b10, 2'b00);

    // load to x0 never stalls
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check("lx0_ready", 32'(id_ready_o), 1);
    step();
    chk_sels("lx0", 2'b00, 2'b00);

    // multicycle op writing x7, follower reads x7
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    check("mc1_start", 32'(mc_start_o), 1);
    check("mc1_valid", 32'(exe_valid_o), 0);
    check("mc1_ready", 32'(id_ready_o), 0);
    step();
    flush_i = 1'b1;
    #1;
    check("mc2_start", 32'(mc_start_o), 0);
    check("mc2_valid", 32'(exe_valid_o), 0);
    check("mc2_fl_ready", 32'(id_ready_o), 0);
    check("mc2_fl_en", 32'(exe_en_o), 0);
    flush_i = 1'b0;
    step();
    check("mc3_start", 32'(mc_start_o), 0);
    check("mc3_valid", 32'(exe_valid_o), 0);
    check("mc3_ready", 32'(id_ready_o), 0);
    step();
    check("mc4_valid", 32'(exe_valid_o), 1);
    check("mc4_ready", 32'(id_ready_o), 1);
    check("mc4_start", 32'(mc_start_o), 0);
    step();
    chk_sels("mc_dep", 2'b01, 2'b00);

    // hold with mem stalled for 5 cycles
    mem_ready_i = 1'b0;
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(exe_valid_o), 1);
      check("hold_ready", 32'(id_ready_o), 0);
      check("hold_en", 32'(exe_en_o), 0);
      chk_sels("hold", 2'b01, 2'b00);
      step();
    end
    mem_ready_i = 1'b1;
    #1;
    check("rel_ready", 32'(id_ready_o), 1);
    step();
    chk_sels("rel_dep", 2'b01, 2'b00);
    idle();
    check("rel_valid", 32'(exe_valid_o), 1);
    step();
    check("rel_once", 32'(exe_valid_o), 0);

    // branch in EXE flushes the decode instr writing x9
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    flush_i = 1'b1;
    #1;
    check("fl_ready", 32'(id_ready_o), 1);
    step();
    flush_i = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check("fl_bub_valid", 32'(exe_valid_o), 0);
    chk_sels("fl_bub", 2'b00, 2'b00);
    step();
    chk_sels("fl_drop", 2'b00, 2'b00);

    // load-use coinciding with flush: flush wins
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    flush_i = 1'b1;
    #1;
    check("lufl_ready", 32'(id_ready_o), 1);
    step();
    flush_i = 1'b0;
    idle();
    check("lufl_valid", 32'(exe_valid_o), 0);

    // async reset in the middle of a multicycle op
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1);
    step();
    idle();
    check("rmc_start", 32'(mc_start_o), 1);
    rst = 1'b0;
    #1;
    check("rmc_start0", 32'(mc_start_o), 0);
    check("rmc_valid", 32'(exe_valid_o), 0);
    check("rmc_ready", 32'(id_ready_o), 0);
    check("rmc_en", 32'(exe_en_o), 0);
    chk_sels("rmc", 2'b00, 2'b00);
    step();
    rst = 1'b1;
    drive(1'b1, 5'd11, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    check("post_ready", 32'(id_ready_o), 1);
    step();
    idle();
    chk_sels("post", 2'b00, 2'b00);
    check("post_valid", 32'(exe_valid_o), 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
